count_uart_tx: RTL and testbench
================================

// Module: count_uart_tx
// PURPOSE
//   Downstream consumer of the 4-bit prescaled counter value. Watches data[3:0], and on every change
//   sends the new value over a serial line as one ASCII hex character, optionally followed by CR LF.
//   The python host reads this stream to follow the counter. 8N1 framing, LSB first, idle-high line.
// PARAMETERS
//   BAUD_DIV   104  clk cycles per serial bit (12 MHz / 115200); legal range >= 2
//   SEND_CRLF  1    1: each message is hex char + 0x0D + 0x0A; 0: hex char only
// PORTS
//   clk    in   1  system clock; the only clock in this block
//   rstn   in   1  reset, asynchronous, active-low
//   data   in   4  counter value; may change on any clk edge (comes from the prescaled domain)
//   tx     out  1  serial output, idle 1
//   busy   out  1  1 while a message (all of its characters) is being shifted out
//   sent   out  1  one-cycle pulse when the final stop bit of a message completes
// BEHAVIOUR
//   Reset (rstn=0, async): tx=1, busy=0, sent=0, FSM=IDLE, both counters 0, sync regs=0,
//     last=0, pending flag=0. tx returns to 1 at once on reset, even mid-frame; the interrupted
//     message is discarded. After release, an input of 0 sends nothing (last=0).
//   Input path: 2-flop synchroniser s1->s2. Change = (s2 != last). On change: last<=s2,
//     pend_val<=s2, pend<=1. A change while busy overwrites pend_val; only the newest value is sent.
//     Intermediate values are dropped, and no error is flagged.
//   Latency: data changes before edge k -> s2 updated at k+1 -> pend set at k+2 -> tx falls
//     (start bit) at edge k+3 if IDLE.
//   Encoding: v<=9 -> 8'h30+v; v>=10 -> 8'h37+v ('A'..'F' = 8'h41..8'h46).
//   FSM: IDLE -> START -> DATA -> STOP -> (next char ? START : IDLE)
//     IDLE : tx=1. If pend: load shift reg with encoded pend_val, clear pend, char_idx=0,
//            busy=1, go to START.
//     START: tx=0 for BAUD_DIV cycles.
//     DATA : 8 bits, LSB first, each held BAUD_DIV cycles; 3-bit bit counter.
//     STOP : tx=1 for BAUD_DIV cycles. At its end, if SEND_CRLF and char_idx<2: char_idx++,
//            load 8'h0D (idx1) / 8'h0A (idx2), go to START with no idle cycle in between.
//            Otherwise: sent=1 for 1 cycle, busy=0, go to IDLE.
//   If pend is already set when STOP ends, IDLE loads it on the next cycle. The gap between
//     messages is exactly 1 idle-high cycle.
//   Baud counter: counts 0..BAUD_DIV-1, wraps, and restarts at 0 on each state entry.
//     Character duration = exactly 10*BAUD_DIV cycles. Message = 10*BAUD_DIV*(SEND_CRLF?3:1).
//   busy rises on the same edge tx falls for the first start bit. It falls on the edge sent pulses.
//   Change arriving in the same cycle as the STOP->IDLE transition: it is captured in pend and
//     sent next; it is never lost.
//   All outputs are registered. tx must never glitch.
// TESTING (bench overrides BAUD_DIV=4)
//   1 Reset with data=0, hold 200 cycles -> tx stays 1, busy=0, sent never pulses.
//   2 SEND_CRLF=0, data 0->5 at edge k -> tx falls at k+3; bits 0,1,0,1,0,1,1,0,0,1 (0x35);
//     every bit 4 cycles; sent pulses at k+3+40; busy high for exactly 40 cycles.
//   3 SEND_CRLF=1, data->4'hB -> bytes 0x42,0x0D,0x0A back-to-back, 120 cycles total, one sent pulse.
//   4 SEND_CRLF=0, while sending '1', data goes 2 then 3 -> next message is '3' only, 1 idle cycle later.
//   5 Assert rstn=0 during DATA of a frame -> tx=1 asynchronously; after release with data=0, no output.
//   6 Sweep data 0..F, waiting for sent each time -> received chars "0123456789ABCDEF" decode correctly.

Source files
------------

// File: rtl/count_uart_tx.sv
// Serialises every change of a 4-bit counter value as one ASCII hex character
// (optionally followed by CR LF) on an 8N1, LSB-first, idle-high UART line.
module count_uart_tx #(
  parameter int unsigned BAUD_DIV  = 104,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] data,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    char_idx;
  logic [7:0]    shreg;
  logic [3:0]    s1, s2, last, pend_val;
  logic          pend;
  logic          baud_done, more, change;
  logic          tx_nxt, busy_nxt, sent_nxt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    return (v <= 4'd9) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign more      = SEND_CRLF && (char_idx < 2'd2);
  assign change    = (s2 != last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = START;
      START:   if (baud_done) state_nxt = DATA;
      DATA:    if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (baud_done) state_nxt = more ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next value of the registered line outputs, so tx changes only on clock edges
  always_comb begin
    tx_nxt   = tx;
    busy_nxt = busy;
    sent_nxt = 1'b0;
    case (state)
      IDLE: if (pend) begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      START: if (baud_done) tx_nxt = shreg[0];
      DATA:  if (baud_done) tx_nxt = (bit_cnt == 3'd7) ? 1'b1 : shreg[1];
      STOP: if (baud_done) begin
        if (more) begin
          tx_nxt = 1'b0;
        end else begin
          tx_nxt   = 1'b1;
          busy_nxt = 1'b0;
          sent_nxt = 1'b1;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      sent     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_idx <= '0;
      shreg    <= '0;
      s1       <= '0;
      s2       <= '0;
      last     <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
    end else begin
      s1   <= data;
      s2   <= s1;
      tx   <= tx_nxt;
      busy <= busy_nxt;
      sent <= sent_nxt;
      if (state == IDLE || state_nxt != state || baud_done) baud_cnt <= '0;
      else                                                   baud_cnt <= baud_cnt + CW'(1);
      case (state)
        IDLE: if (pend) begin
          shreg    <= hex_ascii(pend_val);
          pend     <= 1'b0;
          char_idx <= 2'd0;
        end
        START: bit_cnt <= 3'd0;
        DATA: if (baud_done) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        STOP: if (baud_done && more) begin
          char_idx <= char_idx + 2'd1;
          shreg    <= (char_idx == 2'd0) ? 8'h0D : 8'h0A;
        end
        default: ;
      endcase
      // A fresh change wins over the IDLE load so the newest value is never lost
      if (change) begin
        last     <= s2;
        pend_val <= s2;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: two instances (hex only / hex+CRLF) with UART
// receivers that check each frame against a queue of expected characters.
module tb_count_uart_tx;

  localparam int unsigned BAUD = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] data0 = 4'h0, data1 = 4'h0;
  logic       tx0, busy0, sent0, tx1, busy1, sent1;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int rx_cnt[2]    = '{0, 0};
  int sent_cnt[2]  = '{0, 0};
  int busy_cyc[2]  = '{0, 0};
  int low_cyc[2]   = '{0, 0};
  int last_fall[2] = '{0, 0};
  int last_sent[2] = '{0, 0};
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  count_uart_tx #(.BAUD_DIV(BAUD), .SEND_CRLF(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .data(data0), .tx(tx0), .busy(busy0), .sent(sent0));
  count_uart_tx #(.BAUD_DIV(BAUD), .SEND_CRLF(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .data(data1), .tx(tx1), .busy(busy1), .sent(sent1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sent0 === 1'b1) begin sent_cnt[0]++; last_sent[0] = cyc; end
    if (sent1 === 1'b1) begin sent_cnt[1]++; last_sent[1] = cyc; end
    if (busy0 === 1'b1) busy_cyc[0]++;
    if (busy1 === 1'b1) busy_cyc[1]++;
    if (tx0 === 1'b0) low_cyc[0]++;
    if (tx1 === 1'b0) low_cyc[1]++;
  end

  // UART receiver: samples every cycle of a frame, checks framing and bit width, pops scoreboard
  task automatic rx_loop(input int w);
    logic prev, cur, steady, abort;
    logic [9:0] bits;
    logic [7:0] got, exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      cur = (w == 0) ? tx0 : tx1;
      if (rstn && prev === 1'b1 && cur === 1'b0) begin
        last_fall[w] = cyc;
        steady = 1'b1;
        abort  = 1'b0;
        bits   = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < int'(BAUD); s++) begin
            if (b != 0 || s != 0) begin
              @(negedge clk);
              cur = (w == 0) ? tx0 : tx1;
            end
            if (!rstn) abort = 1'b1;
            if (s == 0) bits[b] = cur;
            else if (cur !== bits[b]) steady = 1'b0;
          end
        end
        prev = cur;
        if (!abort) begin
          got = bits[8:1];
          n_tests++;
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || !steady) begin
            n_fail++;
            $display("FAIL rx%0d_frame bits=%b steady=%b required start=0 stop=1 steady=1", w, bits, steady);
          end
          n_tests++;
          if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL rx%0d_unexpected got=%h required no character", w, got);
          end else begin
            if (w == 0) exp = q0.pop_front();
            else        exp = q1.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL rx%0d_char got=%h required %h", w, got, exp);
            end
          end
          rx_cnt[w]++;
        end
      end else begin
        prev = cur;
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  task automatic wait_sent(input int w, input int prev, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sent_cnt[w] != prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int l0, l1;
    rstn = 1'b0; data0 = 4'h0; data1 = 4'h0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (tx0 !== 1'b1 || tx1 !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b %b required 1 1", tx0, tx1); end
    n_tests++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || sent0 !== 1'b0 || sent1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_sent got %b%b %b%b required 00 00", busy0, busy1, sent0, sent1);
    end
    rstn = 1'b1;
    l0 = low_cyc[0]; l1 = low_cyc[1];
    repeat (200) @(negedge clk);
    n_tests++;
    if (low_cyc[0] != l0 || low_cyc[1] != l1) begin
      n_fail++; $display("FAIL idle_tx low cycles %0d %0d required 0 0", low_cyc[0] - l0, low_cyc[1] - l1);
    end
    n_tests++;
    if (sent_cnt[0] != 0 || sent_cnt[1] != 0 || busy_cyc[0] != 0 || busy_cyc[1] != 0) begin
      n_fail++; $display("FAIL idle_sent_busy sent %0d %0d busy %0d %0d required all 0",
                         sent_cnt[0], sent_cnt[1], busy_cyc[0], busy_cyc[1]);
    end
  endtask

  task automatic test_single_char;
    int k, s, b, r;
    bit ok;
    @(negedge clk);
    k = cyc + 1;
    s = sent_cnt[0]; b = busy_cyc[0]; r = rx_cnt[0];
    data0 = 4'h5;
    q0.push_back(8'h35);
    wait_sent(0, s, 100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout sent count %0d required %0d", sent_cnt[0], s + 1); end
    @(negedge clk);
    n_tests++;
    if (last_fall[0] != k + 3) begin n_fail++; $display("FAIL single_latency fall at %0d required %0d", last_fall[0], k + 3); end
    n_tests++;
    if (last_sent[0] != k + 43) begin n_fail++; $display("FAIL single_sent at %0d required %0d", last_sent[0], k + 43); end
    n_tests++;
    if (busy_cyc[0] - b != 40) begin n_fail++; $display("FAIL single_busy %0d cycles required 40", busy_cyc[0] - b); end
    n_tests++;
    if (rx_cnt[0] - r != 1 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL single_rx frames %0d busy %b required 1 0", rx_cnt[0] - r, busy0);
    end
  endtask

  task automatic test_crlf;
    int k, s, b, r;
    bit ok;
    @(negedge clk);
    k = cyc + 1;
    s = sent_cnt[1]; b = busy_cyc[1]; r = rx_cnt[1];
    data1 = 4'hB;
    q1.push_back(8'h42); q1.push_back(8'h0D); q1.push_back(8'h0A);
    wait_sent(1, s, 300, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL crlf_timeout sent count %0d required %0d", sent_cnt[1], s + 1); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (last_sent[1] != k + 123) begin n_fail++; $display("FAIL crlf_sent at %0d required %0d", last_sent[1], k + 123); end
    n_tests++;
    if (busy_cyc[1] - b != 120) begin n_fail++; $display("FAIL crlf_busy %0d cycles required 120", busy_cyc[1] - b); end
    n_tests++;
    if (rx_cnt[1] - r != 3 || sent_cnt[1] - s != 1) begin
      n_fail++; $display("FAIL crlf_count frames %0d pulses %0d required 3 1", rx_cnt[1] - r, sent_cnt[1] - s);
    end
  endtask

  task automatic test_back_to_back;
    int s, r, t;
    bit ok;
    @(negedge clk);
    s = sent_cnt[0]; r = rx_cnt[0];
    data0 = 4'h1;
    q0.push_back(8'h31);
    repeat (12) @(negedge clk);
    data0 = 4'h2;
    repeat (8) @(negedge clk);
    data0 = 4'h3;
    q0.push_back(8'h33);
    wait_sent(0, s, 100, ok);
    t = last_sent[0];
    wait_sent(0, s + 1, 100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_timeout sent count %0d required %0d", sent_cnt[0], s + 2); end
    repeat (60) @(negedge clk);
    n_tests++;
    if (last_fall[0] != t + 1) begin n_fail++; $display("FAIL b2b_gap second start at %0d required %0d", last_fall[0], t + 1); end
    n_tests++;
    if (rx_cnt[0] - r != 2 || q0.size() != 0) begin
      n_fail++; $display("FAIL b2b_count frames %0d left %0d required 2 0", rx_cnt[0] - r, q0.size());
    end
  endtask

  task automatic test_reset_mid;
    int s, r, l;
    @(negedge clk);
    data0 = 4'h7;
    q0.push_back(8'h37);
    repeat (15) @(negedge clk);
    #2;
    rstn = 1'b0; data0 = 4'h0; data1 = 4'h0;
    #1;
    n_tests++;
    if (tx0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL async_reset tx %b busy %b required 1 0", tx0, busy0); end
    q0.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    s = sent_cnt[0]; r = rx_cnt[0]; l = low_cyc[0];
    repeat (100) @(negedge clk);
    n_tests++;
    if (sent_cnt[0] != s || rx_cnt[0] != r || low_cyc[0] != l) begin
      n_fail++; $display("FAIL post_reset_quiet sent %0d frames %0d low %0d required 0 0 0",
                         sent_cnt[0] - s, rx_cnt[0] - r, low_cyc[0] - l);
    end
  endtask

  task automatic test_sweep;
    string hexs = "0123456789ABCDEF";
    int r, s, v;
    bit ok;
    r = rx_cnt[0];
    for (int i = 1; i <= 16; i++) begin
      v = i % 16;
      @(negedge clk);
      s = sent_cnt[0];
      data0 = 4'(v);
      q0.push_back(hexs[v]);
      wait_sent(0, s, 100, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL sweep_timeout value %0d sent count %0d required %0d", v, sent_cnt[0], s + 1); end
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (rx_cnt[0] - r != 16 || q0.size() != 0) begin
      n_fail++; $display("FAIL sweep_count frames %0d left %0d required 16 0", rx_cnt[0] - r, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_crlf();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
